fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, width of one FIFO write word.
REQ-002 The block SHALL expose parameter NUM_REQ, default 2, number of requesters (legal range 2..4).
REQ-003 The block SHALL expose parameter MAX_FRAME, default 16, maximum beats per granted frame.
REQ-004 w_clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-005 w_rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  marks the final beat of the requester's frame.
REQ-009 req_ready  output  NUM_REQ  per-requester beat accept.
REQ-010 w_full  input  1  FIFO full flag from the write-pointer block.
REQ-011 w_inc  output  1  registered FIFO write request.
REQ-012 w_data  output  DATA_WIDTH  registered FIFO write data.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the current owner; valid while busy.
REQ-014 busy  output  1  high while state is LOCKED.
REQ-015 frame_err  output  1  one-cycle pulse on forced release at MAX_FRAME.

Function
REQ-016 The block SHALL implement FSM states IDLE and LOCKED.
REQ-017 In IDLE, if any req_valid is high, the block SHALL grant the first valid requester at or after the round-robin pointer (wrapping), load grant_id, and enter LOCKED next cycle; req_ready SHALL be all-zero in IDLE.
REQ-018 In LOCKED, req_ready[grant_id] SHALL equal (!w_inc || !w_full); all other req_ready bits SHALL be 0.
REQ-019 A beat SHALL transfer when req_valid[grant_id] && req_ready[grant_id]; its data SHALL appear on w_data with w_inc=1 on the next cycle (1-cycle latency).
REQ-020 A FIFO write SHALL occur in a cycle where w_inc && !w_full; w_inc SHALL deassert after that edge unless a new beat transfers in the same cycle.
REQ-021 While w_inc && w_full, w_inc and w_data SHALL hold stable and no new beat SHALL be accepted.
REQ-022 A transferred beat with req_last=1 SHALL return the FSM to IDLE next cycle and set the round-robin pointer to (grant_id+1) mod NUM_REQ.
REQ-023 A beat counter SHALL count accepted beats in the frame; when the MAX_FRAME-th beat transfers without req_last, the block SHALL return to IDLE, advance the pointer as in REQ-022, and pulse frame_err for one cycle.
REQ-024 Ownership SHALL never change mid-frame; other requesters' req_valid SHALL be ignored in LOCKED.
REQ-025 A pending output word (w_inc=1) SHALL still be written after a return to IDLE; a new grant MAY be issued while it is pending.
REQ-026 Deassertion of req_valid[grant_id] mid-frame SHALL keep the grant (no timeout).

Reset
REQ-027 On w_rst_n low, the block SHALL immediately force state IDLE, w_inc=0, w_data=0, grant_id=0, busy=0, frame_err=0, req_ready=0, pointer=0, beat counter=0.
REQ-028 Reset mid-frame SHALL discard the pending output word and the partial frame.

Structure
REQ-029 The FSM state encoding and default parameter values SHALL live in the shared async-FIFO package.
REQ-030 The round-robin priority selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, any-grant).

Verification
REQ-031 Single requester 0 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3), w_full=0 -> w_inc high 3 consecutive cycles with data A1,A2,A3; busy drops after the last beat.
REQ-032 Both requesters valid from reset, each sending 2-beat frames -> grant order 0,1,0,1; no interleaving of beats within a frame.
REQ-033 w_full asserted for 4 cycles while w_inc=1 with w_data=0x5C -> w_data holds 0x5C, req_ready[grant_id]=0, single write when w_full drops.
REQ-034 Requester 1 streams 16 beats without last (MAX_FRAME=16) -> frame_err pulses once, FSM returns to IDLE, requester 0 granted next if valid.
REQ-035 Reset asserted during LOCKED with w_inc=1 -> all outputs 0 immediately; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the async-FIFO write side.
//   - wr_state_e : write arbiter FSM state encoding (IDLE / LOCKED)
//   - DEF_*      : default parameter values for fifo_wr_arbiter
package fifo_wr_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_MAX_FRAME  = 16;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } wr_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority requester index
//   gnt_idx : first requesting index at or after ptr (wrapping)
//   gnt_any : high when any request bit is set
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int cand;

  // Walk offsets from the farthest to the nearest so the candidate closest
  // to ptr is written last and therefore wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (req[cand[IDX_W-1:0]]) begin
        gnt_idx = cand[IDX_W-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-locked round-robin write arbiter in front of an async FIFO.
// Ports:
//   w_clk, w_rst_n : write clock, asynchronous active-low reset
//   req_valid/req_data/req_last/req_ready : per-requester beat handshake
//   w_full  : FIFO full flag
//   w_inc, w_data : registered FIFO write request / data
//   grant_id, busy : current owner and LOCKED indicator
//   frame_err : one-cycle pulse when a frame is cut at MAX_FRAME beats
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_FRAME  = DEF_MAX_FRAME
) (
  input  logic                          w_clk,
  input  logic                          w_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          w_full,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(MAX_FRAME - 1);

  wr_state_e             state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  w_inc_q, w_inc_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  frame_err_q, frame_err_d;

  logic [DATA_WIDTH-1:0] beat_data [NUM_REQ];
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;
  logic                  slot_free;
  logic                  xfer;
  logic                  at_limit;
  logic                  frame_end;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The output register can take a new word when it is empty or is being
  // drained into the FIFO this cycle.
  assign slot_free = !w_inc_q || !w_full;
  assign xfer      = (state_q == ST_LOCKED) && req_valid[grant_q] && slot_free;
  assign at_limit  = (cnt_q == FINAL_CNT);
  assign frame_end = xfer && (req_last[grant_q] || at_limit);

  // State register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      w_inc_q     <= 1'b0;
      w_data_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      w_inc_q     <= w_inc_d;
      w_data_q    <= w_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    w_inc_d     = w_inc_q;
    w_data_d    = w_data_q;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_LOCKED;
          grant_d = arb_idx;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (frame_end) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            ptr_d       = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
            frame_err_d = !req_last[grant_q];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending word keeps draining independent of the FSM state, so a
    // word accepted on the final beat is still written after IDLE.
    if (xfer) begin
      w_inc_d  = 1'b1;
      w_data_d = beat_data[grant_q];
    end else if (w_inc_q && !w_full) begin
      w_inc_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if (state_q == ST_LOCKED) begin
      req_ready[grant_q] = slot_free;
    end
    busy = (state_q == ST_LOCKED);
  end

  assign w_inc     = w_inc_q;
  assign w_data    = w_data_q;
  assign grant_id  = grant_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (default parameters).
module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        w_full;
  logic        w_inc;
  logic [7:0]  w_data;
  logic [0:0]  grant_id;
  logic        busy;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  // Observation logs written only by the monitor process.
  logic [7:0] wr_log[$];
  logic [0:0] gnt_log[$];
  int         err_pulses = 0;
  logic       busy_prev  = 1'b0;

  // Frame stimulus per requester: {last, data}
  logic [8:0] bq0[$];
  logic [8:0] bq1[$];

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter dut (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_inc     (w_inc),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Inputs change at the falling edge; this samples 3 time units later,
  // i.e. the values the next rising edge will act on.
  always begin
    @(negedge w_clk);
    #3;
    if (w_inc && !w_full) wr_log.push_back(w_data);
    if (busy && !busy_prev) gnt_log.push_back(grant_id);
    if (frame_err) err_pulses++;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic set_req(input int r, input bit v, input logic [7:0] d, input bit l);
    req_valid[r]       = v;
    req_data[r*8 +: 8] = d;
    req_last[r]        = l;
  endtask

  task automatic do_reset();
    w_rst_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    w_full    = 1'b0;
    @(negedge w_clk);
    #1;
    chk("rst_w_inc", w_inc, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  // Drives the frames in bq0/bq1 and compares the FIFO write stream and
  // grant order against a frame-level round-robin prediction.
  task automatic run_traffic(input string tag, input int bubble, input int full_pct);
    logic [8:0] c0[$];
    logic [8:0] c1[$];
    logic [7:0] exp_w[$];
    logic [0:0] exp_g[$];
    logic [8:0] b;
    logic [1:0] exp_rdy;
    int ptr, r, wb, gb, cyc;
    bit sof0, sof1, hs0, hs1;

    c0 = bq0;
    c1 = bq1;
    ptr = 0;
    while (c0.size() + c1.size() > 0) begin
      r = ptr;
      if (r == 0 && c0.size() == 0) r = 1;
      else if (r == 1 && c1.size() == 0) r = 0;
      exp_g.push_back(r[0:0]);
      do begin
        b = (r == 0) ? c0.pop_front() : c1.pop_front();
        exp_w.push_back(b[7:0]);
      end while (!b[8]);
      ptr = (r + 1) % 2;
    end

    wb = wr_log.size();
    gb = gnt_log.size();
    sof0 = 1'b1;
    sof1 = 1'b1;
    cyc = 0;
    while ((bq0.size() + bq1.size() > 0 || w_inc) && cyc < 3000) begin
      if (bq0.size() > 0) set_req(0, sof0 || ($urandom_range(99) >= bubble), bq0[0][7:0], bq0[0][8]);
      else set_req(0, 1'b0, 8'h00, 1'b0);
      if (bq1.size() > 0) set_req(1, sof1 || ($urandom_range(99) >= bubble), bq1[0][7:0], bq1[0][8]);
      else set_req(1, 1'b0, 8'h00, 1'b0);
      w_full = ($urandom_range(99) < full_pct);
      #1;
      exp_rdy = '0;
      if (busy && (!w_inc || !w_full)) exp_rdy[grant_id] = 1'b1;
      chk({tag, "_ready"}, req_ready, exp_rdy);
      hs0 = req_valid[0] && req_ready[0];
      hs1 = req_valid[1] && req_ready[1];
      @(posedge w_clk);
      if (hs0) begin
        sof0 = bq0[0][8];
        void'(bq0.pop_front());
      end
      if (hs1) begin
        sof1 = bq1[0][8];
        void'(bq1.pop_front());
      end
      @(negedge w_clk);
      cyc++;
    end
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    w_full = 1'b0;
    chk({tag, "_timeout"}, (cyc < 3000), 1);
    chk({tag, "_nwr"}, wr_log.size() - wb, exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) chk({tag, "_wdata"}, wr_log[wb + i], exp_w[i]);
    chk({tag, "_ngnt"}, gnt_log.size() - gb, exp_g.size());
    for (int i = 0; i < exp_g.size(); i++) chk({tag, "_gnt"}, gnt_log[gb + i], exp_g[i]);
  endtask

  initial begin
    int wb, eb, len;

    // Single requester, three beats, no backpressure
    do_reset();
    wb = wr_log.size();
    set_req(0, 1'b1, 8'hA1, 1'b0);
    step();
    chk("s_busy", busy, 1);
    chk("s_grant", grant_id, 0);
    chk("s_winc0", w_inc, 0);
    chk("s_ready", req_ready, 2'b01);
    step();
    chk("s_winc_a1", w_inc, 1);
    chk("s_data_a1", w_data, 8'hA1);
    set_req(0, 1'b1, 8'hA2, 1'b0);
    step();
    chk("s_winc_a2", w_inc, 1);
    chk("s_data_a2", w_data, 8'hA2);
    set_req(0, 1'b1, 8'hA3, 1'b1);
    step();
    chk("s_winc_a3", w_inc, 1);
    chk("s_data_a3", w_data, 8'hA3);
    chk("s_busy_end", busy, 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    step();
    chk("s_winc_off", w_inc, 0);
    chk("s_nwr", wr_log.size() - wb, 3);
    chk("s_wr0", wr_log[wb], 8'hA1);
    chk("s_wr1", wr_log[wb + 1], 8'hA2);
    chk("s_wr2", wr_log[wb + 2], 8'hA3);

    // FIFO full holds the pending word
    do_reset();
    wb = wr_log.size();
    set_req(0, 1'b1, 8'h5C, 1'b0);
    step();
    step();
    chk("f_winc", w_inc, 1);
    chk("f_data", w_data, 8'h5C);
    w_full = 1'b1;
    set_req(0, 1'b1, 8'h5D, 1'b1);
    #1;
    chk("f_ready_blk", req_ready, 2'b00);
    repeat (4) begin
      step();
      chk("f_hold_inc", w_inc, 1);
      chk("f_hold_data", w_data, 8'h5C);
      chk("f_hold_rdy", req_ready, 2'b00);
      chk("f_hold_busy", busy, 1);
    end
    chk("f_nowrite", wr_log.size() - wb, 0);
    w_full = 1'b0;
    #1;
    chk("f_ready_rel", req_ready, 2'b01);
    step();
    chk("f_data2", w_data, 8'h5D);
    chk("f_winc2", w_inc, 1);
    chk("f_busy2", busy, 0);
    chk("f_nwr1", wr_log.size() - wb, 1);
    chk("f_wr0", wr_log[wb], 8'h5C);
    set_req(0, 1'b0, 8'h00, 1'b0);
    step();
    chk("f_winc_off", w_inc, 0);
    chk("f_nwr2", wr_log.size() - wb, 2);

    // Both requesters with two 2-beat frames each: strict alternation
    do_reset();
    bq0.push_back({1'b0, 8'h01}); bq0.push_back({1'b1, 8'h02});
    bq0.push_back({1'b0, 8'h03}); bq0.push_back({1'b1, 8'h04});
    bq1.push_back({1'b0, 8'h11}); bq1.push_back({1'b1, 8'h12});
    bq1.push_back({1'b0, 8'h13}); bq1.push_back({1'b1, 8'h14});
    run_traffic("rr", 0, 0);

    // Frame cut at MAX_FRAME beats
    do_reset();
    wb = wr_log.size();
    eb = err_pulses;
    set_req(1, 1'b1, 8'h10, 1'b0);
    step();
    chk("m_busy", busy, 1);
    chk("m_grant", grant_id, 1);
    set_req(0, 1'b1, 8'hEE, 1'b1);
    for (int k = 0; k < 16; k++) begin
      set_req(1, 1'b1, 8'(16 + k), 1'b0);
      #1;
      chk("m_ready", req_ready, 2'b10);
      step();
      chk("m_data", w_data, 8'(16 + k));
      if (k < 15) begin
        chk("m_ferr_lo", frame_err, 0);
        chk("m_busy_hi", busy, 1);
      end else begin
        chk("m_ferr_hi", frame_err, 1);
        chk("m_busy_lo", busy, 0);
      end
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    step();
    chk("m_next_busy", busy, 1);
    chk("m_next_grant", grant_id, 0);
    chk("m_ferr_once", frame_err, 0);
    step();
    chk("m_r0_done", busy, 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("m_npulse", err_pulses - eb, 1);
    chk("m_nwr", wr_log.size() - wb, 17);
    chk("m_wr15", wr_log[wb + 15], 8'h1F);
    chk("m_wr16", wr_log[wb + 16], 8'hEE);

    // Reset in the middle of a frame with a word pending
    do_reset();
    wb = wr_log.size();
    set_req(0, 1'b1, 8'h77, 1'b0);
    step();
    step();
    chk("r_winc_pre", w_inc, 1);
    chk("r_busy_pre", busy, 1);
    w_rst_n = 1'b0;
    #1;
    chk("r_winc", w_inc, 0);
    chk("r_data", w_data, 0);
    chk("r_busy", busy, 0);
    chk("r_grant", grant_id, 0);
    chk("r_ferr", frame_err, 0);
    chk("r_ready", req_ready, 0);
    step();
    step();
    w_rst_n = 1'b1;
    set_req(0, 1'b1, 8'h78, 1'b1);
    set_req(1, 1'b1, 8'h88, 1'b1);
    step();
    chk("r_post_busy", busy, 1);
    chk("r_post_grant", grant_id, 0);
    step();
    chk("r_post_data", w_data, 8'h78);
    set_req(0, 1'b0, 8'h00, 1'b0);
    step();
    chk("r_second_grant", grant_id, 1);
    step();
    set_req(1, 1'b0, 8'h00, 1'b0);
    step();
    chk("r_nwr", wr_log.size() - wb, 2);
    chk("r_wr0", wr_log[wb], 8'h78);
    chk("r_wr1", wr_log[wb + 1], 8'h88);

    // Randomized frames, mid-frame bubbles and FIFO backpressure
    for (int rep = 0; rep < 3; rep++) begin
      do_reset();
      for (int f = 0; f < 4; f++) begin
        len = $urandom_range(6, 1);
        for (int j = 0; j < len; j++) bq0.push_back({(j == len - 1), 8'($urandom)});
        len = $urandom_range(6, 1);
        for (int j = 0; j < len; j++) bq1.push_back({(j == len - 1), 8'($urandom)});
      end
      run_traffic("rnd", 30, 35);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
